// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus signals of the load/store unit.
// The slave modport is the unit's view; master is the surrounding core and memory.
interface load_store_unit_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_fault;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [3:0]  o_mem_mask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_we, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    output o_ready, o_done, o_rdata, o_misaligned, o_fault,
           o_mem_req, o_mem_addr, o_mem_wen, o_mem_mask, o_mem_wdata
  );

  modport master (
    output i_valid, i_we, i_funct3, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    input  o_ready, o_done, o_rdata, o_misaligned, o_fault,
           o_mem_req, o_mem_addr, o_mem_wen, o_mem_mask, o_mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes size/sign, drives one word-aligned
// memory request with a bounded wait, and returns extended load data with status.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [7:0]  wait_cnt_reg;
  logic        ready_reg;
  logic        done_reg;
  logic [31:0] rdata_reg;
  logic        misaligned_reg;
  logic        fault_reg;
  logic        mem_req_reg;

  logic        illegal_in;
  logic        misaligned_in;
  logic [3:0]  mask_next;
  logic [31:0] wdata_next;
  logic [31:0] load_next;
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Decode of the operation offered on the core side, used only at accept.
  always_comb begin
    illegal_in    = 1'b0;
    misaligned_in = 1'b0;
    case (bus.i_funct3)
      3'b000:         misaligned_in = 1'b0;
      3'b001:         misaligned_in = bus.i_addr[0];
      3'b010:         misaligned_in = (bus.i_addr[1:0] != 2'b00);
      3'b100:         illegal_in    = bus.i_we;
      3'b101: begin
        illegal_in    = bus.i_we;
        misaligned_in = bus.i_addr[0];
      end
      default:        illegal_in    = 1'b1;
    endcase
  end

  // Lane mask and replicated store data derived from the latched request.
  always_comb begin
    mask_next  = 4'b1111;
    wdata_next = wdata_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        mask_next  = 4'b0001 << addr_reg[1:0];
        wdata_next = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        mask_next  = 4'b0011 << {addr_reg[1], 1'b0};
        wdata_next = {2{wdata_reg[15:0]}};
      end
      default: begin
        mask_next  = 4'b1111;
        wdata_next = wdata_reg;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = bus.i_mem_rdata[8*gi +: 8];
  end

  assign byte_sel = rd_lane[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};

  always_comb begin
    load_next = bus.i_mem_rdata;
    case (funct3_reg)
      3'b000:  load_next = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_next = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_next = {24'h000000, byte_sel};
      3'b101:  load_next = {16'h0000, half_sel};
      default: load_next = bus.i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      wait_cnt_reg   <= 8'h0;
      ready_reg      <= 1'b1;
      done_reg       <= 1'b0;
      rdata_reg      <= 32'h0;
      misaligned_reg <= 1'b0;
      fault_reg      <= 1'b0;
      mem_req_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_valid) begin
            we_reg     <= bus.i_we;
            funct3_reg <= bus.i_funct3;
            addr_reg   <= bus.i_addr;
            wdata_reg  <= bus.i_wdata;
            ready_reg  <= 1'b0;
            if (illegal_in || misaligned_in) begin
              state_reg      <= ST_DONE;
              done_reg       <= 1'b1;
              fault_reg      <= illegal_in;
              misaligned_reg <= !illegal_in;
              rdata_reg      <= 32'h0;
            end else begin
              state_reg    <= ST_REQ;
              wait_cnt_reg <= 8'h0;
              mem_req_reg  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // An ack on the final permitted cycle still completes normally.
          if (bus.i_mem_ack) begin
            state_reg   <= ST_DONE;
            mem_req_reg <= 1'b0;
            done_reg    <= 1'b1;
            fault_reg   <= 1'b0;
            rdata_reg   <= we_reg ? 32'h0 : load_next;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg   <= ST_DONE;
            mem_req_reg <= 1'b0;
            done_reg    <= 1'b1;
            fault_reg   <= 1'b1;
            rdata_reg   <= 32'h0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        ST_DONE: begin
          state_reg      <= ST_IDLE;
          ready_reg      <= 1'b1;
          done_reg       <= 1'b0;
          fault_reg      <= 1'b0;
          misaligned_reg <= 1'b0;
          rdata_reg      <= 32'h0;
        end
        default: begin
          state_reg   <= ST_IDLE;
          ready_reg   <= 1'b1;
          done_reg    <= 1'b0;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready      = ready_reg;
  assign bus.o_done       = done_reg;
  assign bus.o_rdata      = rdata_reg;
  assign bus.o_misaligned = misaligned_reg;
  assign bus.o_fault      = fault_reg;
  assign bus.o_mem_req    = mem_req_reg;
  assign bus.o_mem_addr   = mem_req_reg ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign bus.o_mem_wen    = mem_req_reg & we_reg;
  assign bus.o_mem_mask   = mem_req_reg ? mask_next : 4'b0000;
  assign bus.o_mem_wdata  = (mem_req_reg && we_reg) ? wdata_next : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: driver pushes expected memory
// requests and completions, responder and monitor pop and compare independently.
module tb_load_store_unit;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] rdata;
    int          delay;
  } mem_t;

  done_t done_q[$];
  mem_t  mem_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    txn = 0;
  bit    mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the access rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                       output done_t d, output mem_t m, output bit has_mem);
    int unsigned off, size;
    logic [31:0] v;
    bit illegal, mis;
    off     = addr % 4;
    size    = f3 % 4;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
    mis     = !illegal && ((size == 1 && (addr % 2) != 0) || (size == 2 && off != 0));
    d.rdata = 32'h0;
    d.mis   = mis;
    d.fault = illegal;
    has_mem = !(illegal || mis);
    m.addr  = addr - off;
    m.wen   = we;
    m.rdata = rdata;
    m.delay = delay;
    m.mask  = 4'hF;
    m.wdata = we ? wdata : 32'h0;
    if (size == 0) begin
      m.mask  = 4'(1 << off);
      m.wdata = we ? (wdata % 256) * 32'h01010101 : 32'h0;
    end else if (size == 1) begin
      m.mask  = 4'(3 << off);
      m.wdata = we ? (wdata % 65536) * 32'h00010001 : 32'h0;
    end
    if (has_mem && delay >= MW) d.fault = 1'b1;
    if (has_mem && delay < MW && !we) begin
      v = rdata >> (8 * off);
      if (size == 0) begin
        v = v % 256;
        if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (size == 1) begin
        v = v % 65536;
        if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      d.rdata = v;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    done_t d;
    mem_t  m;
    bit    has_mem;
    int    t = 0;
    // Junk valid while busy must be ignored.
    while (!bus.o_ready) begin
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_addr  = $urandom;
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        check32("ready_timeout", {31'h0, bus.o_ready}, 32'h1);
        bus.i_valid = 1'b0;
        return;
      end
    end
    model(we, f3, addr, wdata, rdata, delay, d, m, has_mem);
    if (!has_mem) d.cyc = cyc + 1;
    else if (delay >= MW) d.cyc = cyc + MW + 1;
    else d.cyc = cyc + delay + 2;
    done_q.push_back(d);
    if (has_mem) mem_q.push_back(m);
    bus.i_valid  = 1'b1;
    bus.i_we     = we;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wdata;
    @(posedge clk); #1;
    bus.i_valid  = 1'b0;
    bus.i_wdata  = $urandom;
  endtask

  // Completion monitor.
  initial begin
    done_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        if (bus.o_done) begin
          if (done_q.size() == 0) begin
            check32("unexpected_done", {31'h0, bus.o_done}, 32'h0);
          end else begin
            e = done_q.pop_front();
            txn++;
            $display("txn %0d: cycle %0d rdata=%h misaligned=%b fault=%b", txn, cyc,
                     bus.o_rdata, bus.o_misaligned, bus.o_fault);
            check32("done_rdata", bus.o_rdata, e.rdata);
            check32("done_misaligned", {31'h0, bus.o_misaligned}, {31'h0, e.mis});
            check32("done_fault", {31'h0, bus.o_fault}, {31'h0, e.fault});
            check32("done_cycle", cyc, e.cyc);
          end
        end else begin
          check32("rdata_not_done", bus.o_rdata, 32'h0);
        end
      end
    end
  end

  // Memory responder: checks request fields every REQ cycle, acks after the chosen delay.
  initial begin
    mem_t cur;
    int   n = 0;
    bit   active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!mon_en) begin
        active = 1'b0;
      end else begin
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = $urandom;
        if (bus.o_mem_req) begin
          if (!active) begin
            if (mem_q.size() == 0) begin
              check32("unexpected_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
            end else begin
              cur = mem_q.pop_front();
              active = 1'b1;
              n = 0;
            end
          end
          if (active) begin
            n++;
            check32("mem_addr", bus.o_mem_addr, cur.addr);
            check32("mem_mask", {28'h0, bus.o_mem_mask}, {28'h0, cur.mask});
            check32("mem_wdata", bus.o_mem_wdata, cur.wdata);
            check32("mem_wen", {31'h0, bus.o_mem_wen}, {31'h0, cur.wen});
            if (n == cur.delay + 1) begin
              bus.i_mem_ack   = 1'b1;
              bus.i_mem_rdata = cur.rdata;
              active = 1'b0;
            end
          end
        end else begin
          if (active) begin
            check32("timeout_req_cycles", n, MW);
            active = 1'b0;
          end
          if ($urandom_range(0, 3) == 0) bus.i_mem_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    int t;
    bus.i_valid     = 1'b0;
    bus.i_we        = 1'b0;
    bus.i_funct3    = 3'b000;
    bus.i_addr      = 32'h0;
    bus.i_wdata     = 32'h0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_ready", {31'h0, bus.o_ready}, 32'h1);
    check32("rst_done", {31'h0, bus.o_done}, 32'h0);
    check32("rst_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
    check32("rst_rdata", bus.o_rdata, 32'h0);
    check32("rst_flags", {30'h0, bus.o_fault, bus.o_misaligned}, 32'h0);
    check32("rst_mem_bus", bus.o_mem_addr | bus.o_mem_wdata | {28'h0, bus.o_mem_mask}, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 2);
    issue(1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0);
    issue(1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 1);
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    issue(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    issue(1'b0, 3'b010, 32'h104, 32'h0, 32'h11223344, MW);
    issue(1'b0, 3'b010, 32'h108, 32'h0, 32'h55667788, MW - 1);

    for (int i = 0; i < 250; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, MW + 1));
      bus.i_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    t = 0;
    while ((done_q.size() != 0 || !bus.o_ready) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check32("drain_pending", done_q.size(), 0);
    check32("drain_mem_pending", mem_q.size(), 0);
    mon_en = 1'b0;

    // Reset two cycles into REQ: request drops, no completion, late ack ignored.
    bus.i_mem_ack = 1'b0;
    bus.i_valid   = 1'b1;
    bus.i_we      = 1'b0;
    bus.i_funct3  = 3'b010;
    bus.i_addr    = 32'h300;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check32("rstreq_req_c1", {31'h0, bus.o_mem_req}, 32'h1);
    @(posedge clk); #1;
    check32("rstreq_req_c2", {31'h0, bus.o_mem_req}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check32("rstreq_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
    check32("rstreq_ready", {31'h0, bus.o_ready}, 32'h1);
    check32("rstreq_done", {31'h0, bus.o_done}, 32'h0);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk); #1;
      check32("late_ack_done", {31'h0, bus.o_done}, 32'h0);
      check32("late_ack_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
    end
    bus.i_mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MAX_WAIT, default 15, max REQ-state cycles without i_mem_ack before fault (range 1..255).
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  synchronous, active-low reset.
REQ-004 i_valid  in  1  core presents a memory operation.
REQ-005 o_ready  out  1  unit can accept; transfer when i_valid & o_ready.
REQ-006 i_we  in  1  1 = store, 0 = load.
REQ-007 i_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_addr  in  32  byte address (ALU add result).
REQ-009 i_wdata  in  32  store data (rs2).
REQ-010 o_done  out  1  one-cycle completion pulse.
REQ-011 o_rdata  out  32  extended load data; valid only while o_done.
REQ-012 o_misaligned  out  1  valid with o_done; access misaligned.
REQ-013 o_fault  out  1  valid with o_done; illegal funct3 or timeout.
REQ-014 o_mem_req  out  1  memory request, held until i_mem_ack.
REQ-015 o_mem_addr  out  32  {addr[31:2], 2'b00}.
REQ-016 o_mem_wen  out  1  store request.
REQ-017 o_mem_mask  out  4  byte-lane enables, bit n = byte n.
REQ-018 o_mem_wdata  out  32  lane-replicated store data.
REQ-019 i_mem_ack  in  1  memory completes request this cycle.
REQ-020 i_mem_rdata  in  32  read word, valid with i_mem_ack.

Function
REQ-021 FSM states IDLE, REQ, DONE; o_ready = 1 only in IDLE.
REQ-022 IDLE + accept: latch i_we, i_funct3, i_addr, i_wdata; legal aligned op -> REQ; else -> DONE.
REQ-023 Illegal: funct3 011/110/111, or store with 100/101 -> o_fault=1, no memory request.
REQ-024 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0 -> o_misaligned=1, o_fault=0, no memory request.
REQ-025 In REQ: o_mem_req=1 with addr/mask/wdata/wen stable every cycle until i_mem_ack.
REQ-026 REQ + i_mem_ack -> DONE; capture i_mem_rdata same edge; zero-wait latency accept-to-o_done = 2 cycles.
REQ-027 Wait counter clears on REQ entry, increments per REQ cycle without ack; reaching MAX_WAIT -> DONE with o_fault=1, o_mem_req drops.
REQ-028 Ack in the same cycle the counter hits MAX_WAIT: ack wins, no fault.
REQ-029 DONE lasts exactly one cycle, o_done=1, then IDLE; new accept earliest cycle after DONE.
REQ-030 Mask: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-031 Store wdata: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-032 Load: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-033 o_rdata = 0 for stores, faults, misaligned, and whenever o_done=0.
REQ-034 i_mem_ack outside REQ ignored; i_valid outside IDLE ignored, not queued.

Reset
REQ-035 i_rst_n=0 at an edge -> IDLE, counter 0, latched fields 0.
REQ-036 After reset, all outputs 0 except o_ready=1 (driven from state).
REQ-037 Reset mid-REQ drops o_mem_req next cycle, no o_done; late ack ignored.

Verification
REQ-038 LW addr 0x100, ack cycle 1, rdata 0xDEADBEEF -> o_mem_addr 0x100, mask 1111, o_done cycle 2, o_rdata 0xDEADBEEF.
REQ-039 LB addr 0x103, rdata 0x80FF0000 -> mask 1000, o_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-040 SB addr 0x201, wdata 0x12345678 -> mask 0010, o_mem_wdata 0x78787878, wen=1; SH addr 0x202 -> mask 1100, wdata 0x56785678.
REQ-041 LW addr 0x102 -> no o_mem_req, o_done next cycle, o_misaligned=1; funct3 011 -> o_fault=1.
REQ-042 MAX_WAIT=4, no ack -> o_mem_req 4 cycles, o_done+o_fault next, then o_ready=1; ack on 4th cycle -> no fault.
REQ-043 Reset asserted 2 cycles into REQ -> o_mem_req 0 next cycle, o_ready=1, no o_done.
